// File: rtl/string_uart_tx_pkg.sv
// Shared constants for the string UART transmitter: ASCII codes, frame size
// and the 2-bit serializer state encoding.
package string_uart_tx_pkg;

   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   localparam int UART_FRAME_BITS = 10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_byte.sv
// Single 8N1 frame serializer. It accepts a new byte while idle or on the last
// cycle of a stop bit, so a producer can chain frames with no idle gap.
module uart_tx_byte
   import string_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10417
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
   localparam int DATA_BITS = UART_FRAME_BITS - 2;
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   logic [1:0]    state;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          bit_end;
   logic          frame_end;

   assign bit_end   = (baud_cnt == BAUD_MAX);
   assign frame_end = (state == ST_STOP) && bit_end;
   assign ready     = (state == ST_IDLE) || frame_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else if (valid && ready) begin
         // Start bit goes out on the same edge the byte is taken.
         state    <= ST_START;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= data;
         tx       <= 1'b0;
      end else if (state != ST_IDLE) begin
         baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
         if (bit_end) begin
            case (state)
               ST_START: begin
                  state <= ST_DATA;
                  tx    <= shift[0];
               end
               ST_DATA: begin
                  if (bit_cnt == LAST_BIT) begin
                     state   <= ST_STOP;
                     bit_cnt <= '0;
                     tx      <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  tx    <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/string_uart_tx.sv
// Sends a latched fixed-width ASCII string (leftmost char first) as
// back-to-back 8N1 frames, optionally followed by CR LF.
module string_uart_tx
   import string_uart_tx_pkg::*;
#(
   parameter int NUM_CHARS    = 3,
   parameter int CLKS_PER_BIT = 10417,
   parameter int APPEND_CRLF  = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [8*NUM_CHARS-1:0] str,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   tx
);

   localparam int TOTAL = NUM_CHARS + 2 * APPEND_CRLF;
   localparam int IW    = $clog2(NUM_CHARS + 3);
   localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);

   logic [8*NUM_CHARS-1:0] str_q;
   logic [IW-1:0]          idx;
   logic [IW-1:0]          idx_nxt;
   logic [7:0]             byte_data;
   logic                   byte_valid;
   logic                   byte_ready;
   logic                   accept;
   logic                   frame_end;

   // Indices past the string map onto the CR LF trailer.
   function automatic logic [7:0] char_at(input logic [8*NUM_CHARS-1:0] s,
                                          input logic [IW-1:0] i);
      char_at = ASCII_LF;
      if (i == IW'(NUM_CHARS))
         char_at = ASCII_CR;
      for (int k = 0; k < NUM_CHARS; k++)
         if (i == IW'(k))
            char_at = s[8*(NUM_CHARS-1-k) +: 8];
   endfunction

   assign accept    = !busy && start;
   assign frame_end = busy && byte_ready;
   assign idx_nxt   = idx + 1'b1;

   // First char comes straight from str so the start bit leaves on the accept
   // edge; later chars are fed from the latch at each stop-bit end.
   always_comb begin
      byte_valid = accept;
      byte_data  = char_at(str, '0);
      if (busy) begin
         byte_valid = (idx != LAST_IDX);
         byte_data  = char_at(str_q, idx_nxt);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy  <= 1'b0;
         done  <= 1'b0;
         idx   <= '0;
         str_q <= '0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            busy  <= 1'b1;
            idx   <= '0;
            str_q <= str;
         end else if (frame_end) begin
            if (idx == LAST_IDX) begin
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               idx <= idx_nxt;
            end
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk  (clk),
      .rst  (rst),
      .data (byte_data),
      .valid(byte_valid),
      .ready(byte_ready),
      .tx   (tx)
   );

endmodule

// File: tb/tb_string_uart_tx.sv
// Directed + randomized bench: expected tx/busy/done per cycle come from a
// frame-level model built from the byte list of each send.
module tb_string_uart_tx;

   localparam int C = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] str0, str1;
   logic        start0, start1;
   logic        busy0, done0, tx0;
   logic        busy1, done1, tx1;

   int   checks   = 0;
   int   failures = 0;
   logic txs [0:255];

   string_uart_tx #(.NUM_CHARS(3), .CLKS_PER_BIT(C), .APPEND_CRLF(0)) dut0 (
      .clk(clk), .rst(rst), .str(str0), .start(start0),
      .busy(busy0), .done(done0), .tx(tx0));

   string_uart_tx #(.NUM_CHARS(3), .CLKS_PER_BIT(C), .APPEND_CRLF(1)) dut1 (
      .clk(clk), .rst(rst), .str(str1), .start(start1),
      .busy(busy1), .done(done1), .tx(tx1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic set_start(input int w, input logic v);
      if (w == 0) start0 = v; else start1 = v;
   endtask

   task automatic set_str(input int w, input logic [23:0] s);
      if (w == 0) str0 = s; else str1 = s;
   endtask

   task automatic kick(input int w, input logic [23:0] s);
      @(negedge clk);
      set_str(w, s);
      set_start(w, 1'b1);
   endtask

   task automatic idle_check(input int w, input int n);
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         chk("idle_tx",   (w == 0) ? tx0 : tx1,     1'b1);
         chk("idle_busy", (w == 0) ? busy0 : busy1, 1'b0);
         chk("idle_done", (w == 0) ? done0 : done1, 1'b0);
      end
   endtask

   // Samples j=0..n after the accepting edge; j=n is the done cycle.
   task automatic run_send(input int w, input logic [23:0] s, input int poke_at,
                           input bit keep, input logic [23:0] next_s);
      logic [7:0] q[$];
      int n, f, b;
      logic e;
      for (int i = 0; i < 3; i++) q.push_back(s[23-8*i -: 8]);
      if (w == 1) begin
         q.push_back(8'h0D);
         q.push_back(8'h0A);
      end
      n = q.size() * 10 * C;
      for (int j = 0; j <= n; j++) begin
         @(negedge clk);
         if (j == n) e = 1'b1;
         else begin
            f = j / (10 * C);
            b = (j / C) % 10;
            e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : q[f][b-1];
         end
         chk($sformatf("tx[%0d]", j),   (w == 0) ? tx0 : tx1,     e);
         chk($sformatf("busy[%0d]", j), (w == 0) ? busy0 : busy1, j < n);
         chk($sformatf("done[%0d]", j), (w == 0) ? done0 : done1, j == n);
         if (j < 256) txs[j] = (w == 0) ? tx0 : tx1;
         if (!keep && j == 0) set_start(w, 1'b0);
         set_str(w, 24'($urandom));
         if (j == poke_at) begin
            set_start(w, 1'b1);
            set_str(w, 24'h393939);
         end
         if (j == poke_at + 5) set_start(w, 1'b0);
         if (j == n) begin
            if (keep) begin
               set_start(w, 1'b1);
               set_str(w, next_s);
            end else begin
               set_start(w, 1'b0);
            end
         end
      end
   endtask

   initial begin
      logic [23:0] s1, s2;
      start0 = 1'b0; start1 = 1'b0;
      str0 = '0; str1 = '0;

      repeat (2) @(negedge clk);
      chk("rst_tx0", tx0, 1'b1);   chk("rst_busy0", busy0, 1'b0); chk("rst_done0", done0, 1'b0);
      chk("rst_tx1", tx1, 1'b1);   chk("rst_busy1", busy1, 1'b0); chk("rst_done1", done1, 1'b0);
      rst = 1'b0;
      idle_check(0, 4);

      // "123" without trailer: 120 busy cycles
      kick(0, 24'h313233);
      run_send(0, 24'h313233, -1, 1'b0, 24'h0);

      // "  7" with CR LF: 200 busy cycles
      kick(1, 24'h202037);
      run_send(1, 24'h202037, -1, 1'b0, 24'h0);

      // second start mid-send is dropped and str churns every cycle
      kick(0, 24'h303432);
      run_send(0, 24'h303432, 50, 1'b0, 24'h0);
      idle_check(0, 12);

      // start held high: next send accepted in the done cycle
      s1 = 24'($urandom);
      s2 = 24'($urandom);
      kick(0, s1);
      run_send(0, s1, -1, 1'b1, s2);
      run_send(0, s2, -1, 1'b0, 24'h0);
      idle_check(0, 3);

      // 0x55 alternates every bit: a transition every C cycles
      kick(0, 24'h555555);
      run_send(0, 24'h555555, -1, 1'b0, 24'h0);
      chk("first_start_low", txs[0], 1'b0);
      for (int k = 1; k <= 40; k++)
         chk($sformatf("edge[%0d]", k), txs[k] != txs[k-1], (k % C) == 0);

      for (int r = 0; r < 3; r++) begin
         s1 = 24'($urandom);
         kick(r % 2, s1);
         run_send(r % 2, s1, -1, 1'b0, 24'h0);
      end

      // async reset in DATA of char 1
      kick(1, 24'($urandom));
      @(negedge clk);
      set_start(1, 1'b0);
      repeat (12 * C) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_tx",   tx1,   1'b1);
      chk("mid_rst_busy", busy1, 1'b0);
      chk("mid_rst_done", done1, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      idle_check(1, 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
